// File: rtl/ball_dir_ctrl.sv
// -----------------------------------------------------------------------------
// ball_dir_ctrl
//   Direction / timing controller for a single-ball paddle game. Holds the
//   ball in IDLE until a serve, then issues a periodic step strobe, reflects
//   the ball off the right, top and bottom walls, bounces it off the paddle
//   and detects misses past the left line. All outputs are registered.
//
//   Optional feature (macro BALL_SPEEDUP_EN):
//     defined   - the step period starts at TICK_DIV on every serve and each
//                 paddle hit shortens it by TICK_DIV/8, never below TICK_DIV/4.
//     undefined - the step period is fixed at TICK_DIV.
//
// Ports
//   clk         in   1   system clock
//   reset       in   1   synchronous, active-high
//   pause       in   1   freeze the step counter (state/direction unaffected)
//   serve       in   1   launch request, honoured only in IDLE
//   x_pos       in  10   ball X from the ball stage
//   y_pos       in  10   ball Y from the ball stage
//   paddle_y    in  10   paddle top row
//   x_dir       out  2   2'b10 increment, 2'b01 decrement, 2'b00 hold
//   y_dir       out  2   same encoding as x_dir
//   move_tick   out  1   one-cycle step strobe
//   ball_reset  out  1   re-centre the ball
//   hit         out  1   one-cycle paddle-hit pulse
//   miss_count  out  4   misses since reset (wraps 15 -> 0)
// -----------------------------------------------------------------------------
module ball_dir_ctrl #(
    parameter logic [19:0] TICK_DIV = 20'd100000,
    parameter logic [9:0]  X_MIN    = 10'd0,
    parameter logic [9:0]  X_MAX    = 10'd630,
    parameter logic [9:0]  Y_MIN    = 10'd10,
    parameter logic [9:0]  Y_MAX    = 10'd470,
    parameter logic [9:0]  PADDLE_X = 10'd20,
    parameter logic [9:0]  PADDLE_H = 10'd64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pause,
    input  logic       serve,
    input  logic [9:0] x_pos,
    input  logic [9:0] y_pos,
    input  logic [9:0] paddle_y,
    output logic [1:0] x_dir,
    output logic [1:0] y_dir,
    output logic       move_tick,
    output logic       ball_reset,
    output logic       hit,
    output logic [3:0] miss_count
);

    localparam logic [1:0] DIR_INC  = 2'b10;
    localparam logic [1:0] DIR_DEC  = 2'b01;
    localparam logic [1:0] DIR_HOLD = 2'b00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        MISS = 2'd2
    } state_t;

    state_t      r_state;
    logic [19:0] r_cnt;
    logic        r_toggle;   // alternates the initial vertical direction per serve

    logic [19:0] w_period;
    logic        w_wrap;
    logic [10:0] w_pad_top;
    logic [10:0] w_pad_bot;
    logic        w_hit;
    logic        w_miss;
    logic        w_x_wall;
    logic        w_y_bot;
    logic        w_y_top;

`ifdef BALL_SPEEDUP_EN
    localparam logic [19:0] SPEED_STEP  = TICK_DIV >> 3;
    localparam logic [19:0] SPEED_FLOOR = TICK_DIV >> 2;

    logic [19:0] r_period;
    logic [19:0] w_period_faster;

    assign w_period        = r_period;
    // Saturate at the floor instead of subtracting past it.
    assign w_period_faster = (r_period >= SPEED_FLOOR + SPEED_STEP) ?
                             (r_period - SPEED_STEP) : SPEED_FLOOR;
`else
    assign w_period = TICK_DIV;
`endif

    // '>=' keeps the counter safe if the period shrinks below the current count.
    assign w_wrap = (r_cnt >= w_period - 20'd1);

    // Paddle span compared in 11 bits so paddle_y near the top of the range
    // cannot wrap around and produce a false hit.
    assign w_pad_top = {1'b0, paddle_y};
    assign w_pad_bot = {1'b0, paddle_y} + {1'b0, PADDLE_H} - 11'd1;

    assign w_hit  = (x_dir == DIR_DEC) && (x_pos <= PADDLE_X) &&
                    ({1'b0, y_pos} >= w_pad_top) && ({1'b0, y_pos} <= w_pad_bot);
    assign w_miss = (x_dir == DIR_DEC) && (x_pos <= X_MIN) && !w_hit;

    // Only reflect when travelling toward the wall, so a ball sitting past a
    // wall for several cycles does not oscillate.
    assign w_x_wall = (x_dir == DIR_INC) && (x_pos >= X_MAX);
    assign w_y_bot  = (y_dir == DIR_INC) && (y_pos >= Y_MAX);
    assign w_y_top  = (y_dir == DIR_DEC) && (y_pos <= Y_MIN);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= 20'd0;
            r_toggle   <= 1'b0;
            x_dir      <= DIR_HOLD;
            y_dir      <= DIR_HOLD;
            move_tick  <= 1'b0;
            hit        <= 1'b0;
            ball_reset <= 1'b1;
            miss_count <= 4'd0;
`ifdef BALL_SPEEDUP_EN
            r_period   <= TICK_DIV;
`endif
        end else begin
            move_tick <= 1'b0;
            hit       <= 1'b0;
            case (r_state)
                IDLE: begin
                    ball_reset <= 1'b1;
                    x_dir      <= DIR_HOLD;
                    y_dir      <= DIR_HOLD;
                    r_cnt      <= 20'd0;
                    if (serve && !pause) begin
                        r_state    <= MOVE;
                        ball_reset <= 1'b0;
                        x_dir      <= DIR_INC;
                        y_dir      <= r_toggle ? DIR_DEC : DIR_INC;
                        r_toggle   <= ~r_toggle;
`ifdef BALL_SPEEDUP_EN
                        r_period   <= TICK_DIV;
`endif
                    end
                end

                MOVE: begin
                    if (!pause) begin
                        if (w_wrap) begin
                            r_cnt     <= 20'd0;
                            move_tick <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 20'd1;
                        end
                    end

                    if (w_hit) begin
                        x_dir <= DIR_INC;
                        hit   <= 1'b1;
`ifdef BALL_SPEEDUP_EN
                        r_period <= w_period_faster;
`endif
                    end else if (w_x_wall) begin
                        x_dir <= DIR_DEC;
                    end

                    if (w_y_bot) begin
                        y_dir <= DIR_DEC;
                    end else if (w_y_top) begin
                        y_dir <= DIR_INC;
                    end

                    // A miss overrides everything above: outputs already show
                    // the MISS values while the FSM sits in MISS.
                    if (w_miss) begin
                        r_state    <= MISS;
                        r_cnt      <= 20'd0;
                        move_tick  <= 1'b0;
                        ball_reset <= 1'b1;
                        x_dir      <= DIR_HOLD;
                        y_dir      <= DIR_HOLD;
                        miss_count <= miss_count + 4'd1;
                    end
                end

                MISS: begin
                    r_state    <= IDLE;
                    r_cnt      <= 20'd0;
                    ball_reset <= 1'b1;
                    x_dir      <= DIR_HOLD;
                    y_dir      <= DIR_HOLD;
                end

                default: begin
                    r_state <= IDLE;
                    r_cnt   <= 20'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ball_dir_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ball_dir_ctrl
//   Self-checking bench for ball_dir_ctrl with TICK_DIV=4 (default build).
//   Directed vector table, hand-written pause / miss-wrap sequences, then
//   randomized stimulus against a behavioural model of the game rules.
// -----------------------------------------------------------------------------
module tb_ball_dir_ctrl;

    logic       clk = 1'b0;
    logic       reset, pause, serve;
    logic [9:0] x_pos, y_pos, paddle_y;
    logic [1:0] x_dir, y_dir;
    logic       move_tick, ball_reset, hit;
    logic [3:0] miss_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ball_dir_ctrl #(.TICK_DIV(20'd4)) dut (
        .clk        (clk),
        .reset      (reset),
        .pause      (pause),
        .serve      (serve),
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .paddle_y   (paddle_y),
        .x_dir      (x_dir),
        .y_dir      (y_dir),
        .move_tick  (move_tick),
        .ball_reset (ball_reset),
        .hit        (hit),
        .miss_count (miss_count)
    );

    typedef struct {
        bit rst; bit ps; bit sv;
        int x;   int y;  int py;
        int exd; int eyd; bit etk; bit ebr; bit ehit; int emc;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit rst, input bit ps, input bit sv,
                       input int x, input int y, input int py,
                       input int exd, input int eyd, input bit etk,
                       input bit ebr, input bit ehit, input int emc);
        vec_t v;
        v.rst = rst; v.ps = ps; v.sv = sv; v.x = x; v.y = y; v.py = py;
        v.exd = exd; v.eyd = eyd; v.etk = etk; v.ebr = ebr; v.ehit = ehit; v.emc = emc;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int exd, input int eyd,
                           input bit etk, input bit ebr, input bit ehit, input int emc);
        chk({tag, ".x_dir"},      int'(x_dir),      exd);
        chk({tag, ".y_dir"},      int'(y_dir),      eyd);
        chk({tag, ".move_tick"},  int'(move_tick),  int'(etk));
        chk({tag, ".ball_reset"}, int'(ball_reset), int'(ebr));
        chk({tag, ".hit"},        int'(hit),        int'(ehit));
        chk({tag, ".miss_count"}, int'(miss_count), emc);
    endtask

    // Drive one cycle of inputs, let the edge happen, sample 1 ns later.
    task automatic cyc(input bit rst, input bit ps, input bit sv,
                       input int x, input int y, input int py);
        reset = rst; pause = ps; serve = sv;
        x_pos = 10'(x); y_pos = 10'(y); paddle_y = 10'(py);
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model (game rules, directions as +1/-1/0)
    bit m_play, m_missing, m_tog, m_tick, m_hit, m_br;
    int m_xd, m_yd, m_steps, m_mc;

    function automatic int code(input int d);
        return (d > 0) ? 2 : ((d < 0) ? 1 : 0);
    endfunction

    task automatic model_step(input bit rst, input bit ps, input bit sv,
                              input int x, input int y, input int py);
        bit is_hit, is_miss;
        m_tick = 0; m_hit = 0;
        if (rst) begin
            m_play = 0; m_missing = 0; m_tog = 0; m_xd = 0; m_yd = 0;
            m_br = 1; m_mc = 0; m_steps = 0;
        end else if (m_missing) begin
            m_missing = 0; m_br = 1; m_xd = 0; m_yd = 0;
        end else if (!m_play) begin
            m_br = 1; m_xd = 0; m_yd = 0;
            if (sv && !ps) begin
                m_play = 1; m_br = 0; m_xd = 1;
                m_yd = m_tog ? -1 : 1;
                m_tog = !m_tog; m_steps = 0;
            end
        end else begin
            is_hit  = (m_xd == -1) && (x <= 20) && (y >= py) && (y <= py + 63);
            is_miss = (m_xd == -1) && (x <= 0) && !is_hit;
            if (!ps) begin
                m_steps++;
                m_tick = (m_steps % 4 == 0);
            end
            if (is_hit) begin
                m_hit = 1; m_xd = 1;
            end else if (x >= 630 && m_xd == 1) begin
                m_xd = -1;
            end
            if (y >= 470 && m_yd == 1)       m_yd = -1;
            else if (y <= 10 && m_yd == -1)  m_yd = 1;
            if (is_miss) begin
                m_play = 0; m_missing = 1; m_br = 1; m_xd = 0; m_yd = 0;
                m_tick = 0; m_mc = (m_mc + 1) % 16;
            end
        end
    endtask

    initial begin
        reset = 1'b1; pause = 1'b0; serve = 1'b0;
        x_pos = 10'd300; y_pos = 10'd200; paddle_y = 10'd0;

        // ---------------- directed vector table
        //   rst ps sv  x    y    py    xd yd tk br ht mc
        add(1, 0, 0, 300, 200,   0,    0, 0, 0, 1, 0, 0);  // reset
        add(0, 0, 0, 300, 200,   0,    0, 0, 0, 1, 0, 0);  // idle
        add(0, 0, 1, 300, 200,   0,    2, 2, 0, 0, 0, 0);  // serve
        add(0, 0, 0, 300, 200,   0,    2, 2, 0, 0, 0, 0);
        add(0, 0, 0, 300, 200,   0,    2, 2, 0, 0, 0, 0);
        add(0, 0, 0, 300, 200,   0,    2, 2, 0, 0, 0, 0);
        add(0, 0, 0, 300, 200,   0,    2, 2, 1, 0, 0, 0);  // 4th MOVE edge
        add(0, 0, 0, 300, 200,   0,    2, 2, 0, 0, 0, 0);
        add(0, 0, 0, 300, 200,   0,    2, 2, 0, 0, 0, 0);
        add(0, 0, 0, 300, 200,   0,    2, 2, 0, 0, 0, 0);
        add(0, 0, 0, 300, 200,   0,    2, 2, 1, 0, 0, 0);  // 8th
        add(0, 0, 0, 630, 470,   0,    1, 1, 0, 0, 0, 0);  // corner
        add(0, 0, 0, 630, 470,   0,    1, 1, 0, 0, 0, 0);  // no re-reflect
        add(0, 0, 0,  20, 163, 100,    2, 1, 0, 0, 1, 0);  // hit at last row
        add(0, 0, 0,  20, 163, 100,    2, 1, 1, 0, 0, 0);  // moving away
        add(0, 0, 0, 630, 300, 100,    1, 1, 0, 0, 0, 0);
        add(0, 0, 0,  20, 164, 100,    1, 1, 0, 0, 0, 0);  // just below paddle
        add(0, 0, 0, 300,  10, 100,    1, 2, 0, 0, 0, 0);  // top wall
        add(0, 0, 0,   0, 200, 100,    0, 0, 0, 1, 0, 1);  // miss
        add(0, 0, 0, 300, 200, 100,    0, 0, 0, 1, 0, 1);  // MISS -> IDLE
        add(0, 0, 0,   0, 200, 100,    0, 0, 0, 1, 0, 1);
        add(0, 1, 1, 300, 200, 100,    0, 0, 0, 1, 0, 1);  // paused serve ignored
        add(0, 0, 1, 300, 200, 100,    2, 1, 0, 0, 0, 1);  // toggle -> y dec
        add(0, 0, 1, 300, 200, 100,    2, 1, 0, 0, 0, 1);  // serve ignored
        add(0, 0, 0, 630, 200, 100,    1, 1, 0, 0, 0, 1);
        add(0, 0, 0,   0, 100, 100,    2, 1, 0, 0, 1, 1);  // hit beats miss
        add(0, 0, 0, 300, 200, 100,    2, 1, 1, 0, 0, 1);
        add(1, 0, 0, 300, 200, 100,    0, 0, 0, 1, 0, 0);  // reset mid-MOVE
        add(0, 0, 1, 300, 200, 100,    2, 2, 0, 0, 0, 0);  // toggle cleared

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].rst, tbl[i].ps, tbl[i].sv, tbl[i].x, tbl[i].y, tbl[i].py);
            chk_all($sformatf("vec%0d", i), tbl[i].exd, tbl[i].eyd, tbl[i].etk,
                    tbl[i].ebr, tbl[i].ehit, tbl[i].emc);
        end

        // ---------------- pause holds the counter
        cyc(1, 0, 0, 300, 200, 0);
        cyc(0, 0, 1, 300, 200, 0);
        cyc(0, 0, 0, 300, 200, 0);
        cyc(0, 0, 0, 300, 200, 0);
        chk("pause.pre_tick", int'(move_tick), 0);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1, 0, 300, 200, 0);
            chk($sformatf("pause.tick%0d", i), int'(move_tick), 0);
            chk($sformatf("pause.xdir%0d", i), int'(x_dir), 2);
        end
        cyc(0, 0, 0, 300, 200, 0);
        chk("pause.resume1", int'(move_tick), 0);
        cyc(0, 0, 0, 300, 200, 0);
        chk("pause.resume2", int'(move_tick), 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 300, 200, 0);
            chk($sformatf("pause.after%0d", i), int'(move_tick), 0);
        end
        cyc(0, 0, 0, 300, 200, 0);
        chk("pause.period", int'(move_tick), 1);

        // ---------------- 16 misses wrap the counter
        cyc(1, 0, 0, 300, 400, 0);
        for (int i = 0; i < 16; i++) begin
            cyc(0, 0, 1, 300, 400, 0);
            chk($sformatf("wrap%0d.serve_br", i), int'(ball_reset), 0);
            cyc(0, 0, 0, 630, 400, 0);
            chk($sformatf("wrap%0d.xdec", i), int'(x_dir), 1);
            cyc(0, 0, 0, 0, 400, 0);
            chk($sformatf("wrap%0d.mc", i), int'(miss_count), (i + 1) % 16);
            chk($sformatf("wrap%0d.br", i), int'(ball_reset), 1);
            cyc(0, 0, 0, 300, 400, 0);
            chk($sformatf("wrap%0d.idle_x", i), int'(x_dir), 0);
        end

        // ---------------- randomized run against the model
        cyc(1, 0, 0, 300, 200, 0);
        model_step(1, 0, 0, 300, 200, 0);
        for (int n = 0; n < 3000; n++) begin
            bit rr, pp, ss;
            int xx, yy, pyv, sel;
            rr = ($urandom_range(0, 99) == 0);
            pp = ($urandom_range(0, 3) == 0);
            ss = ($urandom_range(0, 3) == 0);
            sel = $urandom_range(0, 3);
            xx = (sel == 0) ? $urandom_range(0, 25) :
                 (sel == 1) ? $urandom_range(620, 640) : $urandom_range(0, 639);
            sel = $urandom_range(0, 3);
            yy = (sel == 0) ? $urandom_range(0, 15) :
                 (sel == 1) ? $urandom_range(465, 480) : $urandom_range(0, 479);
            sel = $urandom_range(0, 3);
            if (sel == 0)      pyv = $urandom_range(960, 1023);
            else if (sel == 1) pyv = $urandom_range(0, 1023);
            else               pyv = (yy >= 70) ? yy - $urandom_range(0, 66) : $urandom_range(0, 70);
            model_step(rr, pp, ss, xx, yy, pyv);
            cyc(rr, pp, ss, xx, yy, pyv);
            chk_all($sformatf("rnd%0d", n), code(m_xd), code(m_yd), m_tick, m_br, m_hit, m_mc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
